// File: rtl/video_clk_gen_pkg.sv
// Shared types and sizing helpers for the video clock-enable generator.
package video_clk_gen_pkg;

   typedef enum logic [1:0] {
      LOCK_WAIT,
      LOCKED,
      APPLY,
      RELOCK
   } state_t;

   // Channel-select width; a single bit is kept even for degenerate channel counts.
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Lock counter must be able to hold the value LOCK_CYCLES itself.
   function automatic int lock_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/video_clk_gen_if.sv
// Configuration request port: valid/ready handshake plus error pulse.
interface video_clk_gen_if #(
   parameter int CH_W  = 2,
   parameter int DIV_W = 8
);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic [DIV_W-1:0] cfg_phase;
   logic             cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_div, cfg_phase,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
      output cfg_ready, cfg_err
   );

endinterface

// File: rtl/video_clk_gen_ch.sv
// One divider channel: wrapping counter, enable strobe and square-wave output.
module video_clk_gen_ch
   import video_clk_gen_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] new_div,
   input  logic [DIV_W-1:0] new_phase,
   output logic             wrap,
   output logic             clk_en,
   output logic             divclk
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;
   logic [DIV_W:0]   half;

   assign wrap = (cnt == div - DIV_W'(1));
   assign half = ({1'b0, div} + (DIV_W + 1)'(1)) >> 1;

   // Counter runs 0..div-1; a reload replaces the wrap so the period boundary stays clean.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         div <= DIV_W'(DEFAULT_DIV);
      end else if (load) begin
         div <= new_div;
         cnt <= new_phase;
      end else if (wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

   // Registered outputs: strobe after the last count, high phase is the longer half for odd ratios.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_en <= 1'b0;
         divclk <= 1'b0;
      end else begin
         clk_en <= wrap;
         divclk <= ({1'b0, cnt} < half);
      end
   end

endmodule

// File: rtl/video_clk_gen.sv
// Runtime-reconfigurable clock-enable generator with PLL-style lock indication.
module video_clk_gen
   import video_clk_gen_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2,
   parameter int LOCK_CYCLES = 16
) (
   input  logic              refclk,
   input  logic              rst,
   video_clk_gen_if.slave    cfg,
   output logic [NUM_CH-1:0] clk_en,
   output logic [NUM_CH-1:0] divclk,
   output logic              locked
);

   localparam int CH_W   = ch_width(NUM_CH);
   localparam int LOCK_W = lock_width(LOCK_CYCLES);
   localparam logic [CH_W:0]      NUM_CH_V  = (CH_W + 1)'(NUM_CH);
   localparam logic [LOCK_W-1:0]  LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
   localparam logic [DIV_W-1:0]   MIN_DIV   = DIV_W'(2);

   state_t            state;
   state_t            state_next;
   logic [LOCK_W-1:0] lock_cnt;
   logic [LOCK_W-1:0] lock_next;
   logic              ready_q;
   logic              ready_next;
   logic              locked_next;
   logic              err_q;
   logic              err_next;
   logic              capture;
   logic              apply_hit;
   logic [CH_W-1:0]   pend_ch;
   logic [DIV_W-1:0]  pend_div;
   logic [DIV_W-1:0]  pend_phase;
   logic [DIV_W-1:0]  clamp_div;
   logic [DIV_W-1:0]  clamp_phase;
   logic [NUM_CH-1:0] wrap;
   logic [NUM_CH-1:0] load;

   assign clamp_div   = (cfg.cfg_div < MIN_DIV) ? MIN_DIV : cfg.cfg_div;
   assign clamp_phase = (cfg.cfg_phase >= clamp_div) ? '0 : cfg.cfg_phase;
   assign cfg.cfg_ready = ready_q;
   assign cfg.cfg_err   = err_q;

   // Reload only the pending channel, and only on its own wrap cycle.
   always_comb begin
      load = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if ((state == APPLY) && (pend_ch == CH_W'(i)) && wrap[i]) begin
            load[i] = 1'b1;
         end
      end
      apply_hit = |load;
   end

   // Next-state and registered-output decisions for the lock/config sequencer.
   always_comb begin
      state_next  = state;
      lock_next   = lock_cnt;
      ready_next  = ready_q;
      locked_next = locked;
      err_next    = 1'b0;
      capture     = 1'b0;
      case (state)
         LOCK_WAIT, RELOCK: begin
            lock_next = lock_cnt + LOCK_W'(1);
            if (lock_cnt == LOCK_LAST) begin
               state_next  = LOCKED;
               locked_next = 1'b1;
               ready_next  = 1'b1;
            end
         end
         LOCKED: begin
            if (cfg.cfg_valid && ready_q) begin
               if ({1'b0, cfg.cfg_ch} >= NUM_CH_V) begin
                  err_next = 1'b1;
               end else begin
                  capture     = 1'b1;
                  ready_next  = 1'b0;
                  locked_next = 1'b0;
                  state_next  = APPLY;
               end
            end
         end
         APPLY: begin
            if (apply_hit) begin
               lock_next  = '0;
               state_next = RELOCK;
            end
         end
         default: begin
            state_next = LOCK_WAIT;
         end
      endcase
   end

   // Sequencer state, lock counter and handshake/status flags.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state    <= LOCK_WAIT;
         lock_cnt <= '0;
         ready_q  <= 1'b0;
         locked   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_next;
         lock_cnt <= lock_next;
         ready_q  <= ready_next;
         locked   <= locked_next;
         err_q    <= err_next;
      end
   end

   // Hold the accepted request (already clamped) until its channel wraps.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         pend_ch    <= '0;
         pend_div   <= MIN_DIV;
         pend_phase <= '0;
      end else if (capture) begin
         pend_ch    <= cfg.cfg_ch;
         pend_div   <= clamp_div;
         pend_phase <= clamp_phase;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      video_clk_gen_ch #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk       (refclk),
         .rst       (rst),
         .load      (load[g]),
         .new_div   (pend_div),
         .new_phase (pend_phase),
         .wrap      (wrap[g]),
         .clk_en    (clk_en[g]),
         .divclk    (divclk[g])
      );
   end

endmodule
